proj_bbox_locator: RTL and testbench
====================================

Name: proj_bbox_locator

Overview:
Parametrised successor to the 1-bit projection plate locator. Accumulates per-row and per-column counts of target pixels over one frame. Scans both projections against runtime thresholds and emits a margin-adjusted bounding box with a valid pulse. Sits after binarisation and feeds the plate crop/segmentation stage.

Parameters:
H_PIXEL, 1024, active columns per frame
V_PIXEL, 768, active rows per frame
AW, 11, coordinate/address width; 2^AW >= max(H_PIXEL,V_PIXEL)
CNT_W, 11, projection count width; counts saturate at 2^CNT_W-1
BIN_LEVEL, 255, gray_b >= BIN_LEVEL marks a target pixel
MW, 6, margin port width

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
pre_frame_vsync  in  1  frame sync; falling edge = frame start
pre_frame_de  in  1  pixel valid
gray_b  in  8  binarised pixel
xpos  in  AW  pixel column
ypos  in  AW  pixel row
x_y_p  in  1  ROI qualifier; pixel counts only when 1
col_thr  in  CNT_W  column count threshold (>=)
row_thr  in  CNT_W  row count threshold (>=)
mrg_x_st, mrg_x_end, mrg_y_st, mrg_y_end  in  MW each  inward box margins
save_x_st, save_y_st, save_x_end, save_y_end  out  AW each  registered box
bbox_valid  out  1  one-cycle pulse, new box
bbox_found  out  1  1 = box found in last frame
busy  out  1  high in every state except WAIT

Behaviour:
- Reset values: save_x_st=0, save_y_st=0, save_x_end=H_PIXEL-1, save_y_end=V_PIXEL-1, bbox_valid=0, bbox_found=0. FSM enters CLEAR.
- FSM states: CLEAR -> WAIT -> ACCUM -> SCAN -> DONE -> CLEAR.
- CLEAR: idx 0..max(H,V)-1 writes 0 to both count RAMs. Writes beyond a RAM's depth are suppressed. Goes to WAIT after the last write.
- WAIT: goes to ACCUM on the vsync falling edge (vsync_d0 & ~vsync). An edge that falls while in CLEAR is ignored, so that frame is skipped.
- ACCUM, hit definition: hit = de & x_y_p & (gray_b>=BIN_LEVEL).
- ACCUM, column RAM: read-modify-write. Read xpos when de; one cycle later write read_data + hit_d1, saturating.
- ACCUM, row count: accumulated in a register and committed to the row RAM at address ypos on a de pixel with xpos==H_PIXEL-1. The register clears after each commit.
- ACCUM exit: after committing (H_PIXEL-1, V_PIXEL-1), go to SCAN. A vsync falling edge also goes to SCAN (truncated frame); any uncommitted partial row is discarded.
- ACCUM simultaneity: if the last pixel and a vsync edge coincide, the pixel is committed first.
- SCAN: idx 0..max(H,V)-1 reads both RAMs; read latency is 1 cycle.
- SCAN, per axis: a position qualifies when count >= thr. Track first and last qualifying index, ignoring indices beyond the axis depth.
- SCAN duration: max(H,V)+2 cycles.
- DONE, one cycle: st = min(first+mrg_st, N-1) and end = last - mrg_end, floored at 0.
- DONE, found: bbox_found=1 only if both axes qualified and st<=end on both axes. Otherwise bbox_found=0 and the outputs load full frame 0/0/H-1/V-1.
- DONE outputs: the save_* registers update and bbox_valid pulses in the same cycle.
- Outputs hold between pulses.
- Reset mid-operation: any state returns to CLEAR with reset output values. No bbox_valid fires until a complete later frame has been scanned.

Optional Feature:
PROJ_LONGEST_RUN_EN
- Defined: SCAN tracks, per axis, the longest contiguous run of qualifying indices. On equal length the earlier run wins. first/last are that run's bounds. Isolated noise columns and rows are rejected.
- Undefined: first/last qualifying index as above.

Decomposition:
- Package proj_pkg: state enum (CLEAR, WAIT, ACCUM, SCAN, DONE), the function for max(H,V), and the count-saturation helper.
- Sub-module proj_count_ram: simple dual-port RAM with parameters WIDTH and DEPTH, synchronous write, registered 1-cycle read. Instantiated twice: column (depth H_PIXEL) and row (depth V_PIXEL).

Test Plan:
Common setup: H=16, V=8, CNT_W=5, thresholds=1, margins=0, x_y_p=1.
1. All-zero frame -> one bbox_valid, bbox_found=0, box 0,0,15,7.
2. 255 rectangle x4..9, y2..5 -> bbox_found=1, box x_st=4, y_st=2, x_end=9, y_end=5.
3. Same rectangle, margins x 1/2, y 1/1 -> box 5,3,7,4. With mrg_x_st=10 -> bbox_found=0, full frame.
4. Rectangle plus single pixel (13,0), col_thr=2, row_thr=2 -> box 4,2,9,5. Same input with x_y_p=0 throughout -> bbox_found=0.
5. rst pulsed mid-ACCUM -> outputs return to reset values next cycle. No bbox_valid for the interrupted frame; the next full frame yields the correct box.
6. PROJ_LONGEST_RUN_EN, target columns 1..2 and 6..11, rows 2..5 -> defined: x 6..11; undefined: x 1..11.

Source files
------------

// File: rtl/proj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proj_pkg
//  Description : Shared types and helpers for the projection bounding-box
//                locator: FSM state encoding, frame-dimension helper and the
//                projection-count saturation test.
//  Revision    : 1.0 - initial release
// ============================================================================
package proj_pkg;

  // Frame-level sequencing states
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Longer of the two frame dimensions; sets the CLEAR/SCAN sweep length
  function automatic int unsigned max_dim(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // True when a count of the given width has reached its ceiling
  function automatic logic cnt_at_max(input logic [31:0] cnt, input int unsigned width);
    return cnt >= ((32'd1 << width) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/proj_count_ram.sv
`default_nettype none
// ============================================================================
//  Module      : proj_count_ram
//  Description : Simple dual-port count RAM. Synchronous write, registered
//                one-cycle read. Addresses at or beyond DEPTH are ignored on
//                write and read back as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_count_ram #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 1024,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the shared sweep index can run past this array's depth
  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < 32'(DEPTH))) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata_q <= (32'(raddr_i) < 32'(DEPTH)) ? mem_q[raddr_i[IDX_W-1:0]] : '0;
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/proj_bbox_locator.sv
`default_nettype none
// ============================================================================
//  Module      : proj_bbox_locator
//  Description : Builds per-column and per-row target-pixel projections over
//                one frame, scans them against runtime thresholds and emits a
//                margin-adjusted bounding box with a one-cycle valid pulse.
//                Optional macro PROJ_LONGEST_RUN_EN: box bounds come from the
//                longest contiguous qualifying run per axis (earliest on tie).
//  Revision    : 1.0 - initial release
// ============================================================================
module proj_bbox_locator
  import proj_pkg::*;
#(
  parameter int H_PIXEL   = 1024,
  parameter int V_PIXEL   = 768,
  parameter int AW        = 11,
  parameter int CNT_W     = 11,
  parameter int BIN_LEVEL = 255,
  parameter int MW        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pre_frame_vsync,
  input  logic             pre_frame_de,
  input  logic [7:0]       gray_b,
  input  logic [AW-1:0]    xpos,
  input  logic [AW-1:0]    ypos,
  input  logic             x_y_p,
  input  logic [CNT_W-1:0] col_thr,
  input  logic [CNT_W-1:0] row_thr,
  input  logic [MW-1:0]    mrg_x_st,
  input  logic [MW-1:0]    mrg_x_end,
  input  logic [MW-1:0]    mrg_y_st,
  input  logic [MW-1:0]    mrg_y_end,
  output logic [AW-1:0]    save_x_st,
  output logic [AW-1:0]    save_y_st,
  output logic [AW-1:0]    save_x_end,
  output logic [AW-1:0]    save_y_end,
  output logic             bbox_valid,
  output logic             bbox_found,
  output logic             busy
);

  localparam int unsigned N_MAX = max_dim(H_PIXEL, V_PIXEL);
  localparam int          IW    = AW + 1;                     // sweep index reaches N_MAX+1
  localparam int          SW    = ((AW > MW) ? AW : MW) + 1;  // margin arithmetic width

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             vsync_d0_q, de_d1_q, hit_d1_q, rd_vld_q;
  logic [AW-1:0]    xpos_d1_q, rd_idx_q;
  logic [CNT_W-1:0] row_acc_q;
  logic [AW-1:0]    save_x_st_q, save_y_st_q, save_x_end_q, save_y_end_q;
  logic             bbox_valid_q, bbox_found_q;

  logic [1:0]       any_q;
  logic [AW-1:0]    first_q [2];
  logic [AW-1:0]    last_q  [2];

  logic             vs_fall_w, hit_w, row_end_w, frame_end_w, clearing_w;
  logic [CNT_W-1:0] col_rdata_w, row_rdata_w, col_inc_w, row_sum_w;
  logic [1:0]       qual_w;
  logic [SW-1:0]    x_sum_w, y_sum_w, x_st_w, y_st_w, x_end_w, y_end_w;
  logic             found_w;

  assign vs_fall_w   = vsync_d0_q & ~pre_frame_vsync;
  assign hit_w       = pre_frame_de & x_y_p & (gray_b >= 8'(BIN_LEVEL));
  assign row_end_w   = (state_q == ST_ACCUM) & pre_frame_de & (xpos == AW'(H_PIXEL - 1));
  assign frame_end_w = row_end_w & (ypos == AW'(V_PIXEL - 1));
  assign clearing_w  = (state_q == ST_CLEAR);
  assign busy        = (state_q != ST_WAIT);

  // Saturating increments for the column read-modify-write and row accumulator
  assign col_inc_w = (cnt_at_max(32'(col_rdata_w), CNT_W) | ~hit_d1_q) ? col_rdata_w
                                                                       : col_rdata_w + CNT_W'(1);
  assign row_sum_w = (cnt_at_max(32'(row_acc_q), CNT_W) | ~hit_w) ? row_acc_q
                                                                  : row_acc_q + CNT_W'(1);

  proj_count_ram #(.WIDTH(CNT_W), .DEPTH(H_PIXEL), .AW(AW)) u_col_ram (
    .clk     (clk),
    .we_i    (clearing_w | de_d1_q),
    .waddr_i (clearing_w ? idx_q[AW-1:0] : xpos_d1_q),
    .wdata_i (clearing_w ? '0 : col_inc_w),
    .raddr_i ((state_q == ST_ACCUM) ? xpos : idx_q[AW-1:0]),
    .rdata_o (col_rdata_w)
  );

  proj_count_ram #(.WIDTH(CNT_W), .DEPTH(V_PIXEL), .AW(AW)) u_row_ram (
    .clk     (clk),
    .we_i    (clearing_w | row_end_w),
    .waddr_i (clearing_w ? idx_q[AW-1:0] : ypos),
    .wdata_i (clearing_w ? '0 : row_sum_w),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (row_rdata_w)
  );

  // Input edge detect plus the one-cycle delay lines for RMW and scan reads
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d0_q <= 1'b0;
      de_d1_q    <= 1'b0;
      hit_d1_q   <= 1'b0;
      xpos_d1_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      vsync_d0_q <= pre_frame_vsync;
      de_d1_q    <= (state_q == ST_ACCUM) & pre_frame_de;
      hit_d1_q   <= hit_w;
      xpos_d1_q  <= xpos;
      rd_vld_q   <= (state_q == ST_SCAN) & (idx_q < IW'(N_MAX));
      rd_idx_q   <= idx_q[AW-1:0];
    end
  end

  // Row accumulator: commits on the last column, partial rows die on exit
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_ACCUM) || row_end_w) begin
      row_acc_q <= '0;
    end else if (pre_frame_de) begin
      row_acc_q <= row_sum_w;
    end
  end

  // Per-axis qualification of the scanned counts (0 = column, 1 = row)
  always_comb begin
    qual_w    = '0;
    qual_w[0] = rd_vld_q & (32'(rd_idx_q) < 32'(H_PIXEL)) & (col_rdata_w >= col_thr);
    qual_w[1] = rd_vld_q & (32'(rd_idx_q) < 32'(V_PIXEL)) & (row_rdata_w >= row_thr);
  end

`ifdef PROJ_LONGEST_RUN_EN
  logic [1:0]    in_run_q;
  logic [AW-1:0] run_st_q   [2];
  logic [IW-1:0] run_len_q  [2];
  logic [IW-1:0] best_len_q [2];
  logic [AW-1:0] run_st_w   [2];
  logic [IW-1:0] run_len_w  [2];

  // Start and length of the run as extended by the current index
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      run_st_w[a]  = in_run_q[a] ? run_st_q[a] : rd_idx_q;
      run_len_w[a] = in_run_q[a] ? run_len_q[a] + IW'(1) : IW'(1);
    end
  end

  // Keep the longest run; strict compare leaves the earlier run on a tie
  always_ff @(posedge clk) begin
    for (int a = 0; a < 2; a++) begin
      if (rst || (state_q != ST_SCAN)) begin
        any_q[a]      <= 1'b0;
        first_q[a]    <= '0;
        last_q[a]     <= '0;
        in_run_q[a]   <= 1'b0;
        run_st_q[a]   <= '0;
        run_len_q[a]  <= '0;
        best_len_q[a] <= '0;
      end else if (qual_w[a]) begin
        in_run_q[a]  <= 1'b1;
        run_st_q[a]  <= run_st_w[a];
        run_len_q[a] <= run_len_w[a];
        if (run_len_w[a] > best_len_q[a]) begin
          best_len_q[a] <= run_len_w[a];
          first_q[a]    <= run_st_w[a];
          last_q[a]     <= rd_idx_q;
          any_q[a]      <= 1'b1;
        end
      end else if (rd_vld_q) begin
        in_run_q[a] <= 1'b0;
      end
    end
  end
`else
  // Record the first and last qualifying index per axis
  always_ff @(posedge clk) begin
    for (int a = 0; a < 2; a++) begin
      if (rst || (state_q != ST_SCAN)) begin
        any_q[a]   <= 1'b0;
        first_q[a] <= '0;
        last_q[a]  <= '0;
      end else if (qual_w[a]) begin
        if (!any_q[a]) first_q[a] <= rd_idx_q;
        last_q[a] <= rd_idx_q;
        any_q[a]  <= 1'b1;
      end
    end
  end
`endif

  // Margin-adjusted box: start clamps to the axis end, end floors at zero
  always_comb begin
    x_sum_w = SW'(first_q[0]) + SW'(mrg_x_st);
    y_sum_w = SW'(first_q[1]) + SW'(mrg_y_st);
    x_st_w  = (x_sum_w > SW'(H_PIXEL - 1)) ? SW'(H_PIXEL - 1) : x_sum_w;
    y_st_w  = (y_sum_w > SW'(V_PIXEL - 1)) ? SW'(V_PIXEL - 1) : y_sum_w;
    x_end_w = (SW'(last_q[0]) >= SW'(mrg_x_end)) ? SW'(last_q[0]) - SW'(mrg_x_end) : '0;
    y_end_w = (SW'(last_q[1]) >= SW'(mrg_y_end)) ? SW'(last_q[1]) - SW'(mrg_y_end) : '0;
    found_w = any_q[0] & any_q[1] & (x_st_w <= x_end_w) & (y_st_w <= y_end_w);
  end

  // Frame sequencer with registered box outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      idx_q        <= '0;
      save_x_st_q  <= '0;
      save_y_st_q  <= '0;
      save_x_end_q <= AW'(H_PIXEL - 1);
      save_y_end_q <= AW'(V_PIXEL - 1);
      bbox_valid_q <= 1'b0;
      bbox_found_q <= 1'b0;
    end else begin
      bbox_valid_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          if (idx_q == IW'(N_MAX - 1)) begin
            state_q <= ST_WAIT;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_WAIT: begin
          if (vs_fall_w) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (frame_end_w || vs_fall_w) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
          end
        end
        ST_SCAN: begin
          if (idx_q == IW'(N_MAX + 1)) begin
            state_q <= ST_DONE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          state_q      <= ST_CLEAR;
          bbox_valid_q <= 1'b1;
          bbox_found_q <= found_w;
          if (found_w) begin
            save_x_st_q  <= AW'(x_st_w);
            save_y_st_q  <= AW'(y_st_w);
            save_x_end_q <= AW'(x_end_w);
            save_y_end_q <= AW'(y_end_w);
          end else begin
            save_x_st_q  <= '0;
            save_y_st_q  <= '0;
            save_x_end_q <= AW'(H_PIXEL - 1);
            save_y_end_q <= AW'(V_PIXEL - 1);
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign save_x_st  = save_x_st_q;
  assign save_y_st  = save_y_st_q;
  assign save_x_end = save_x_end_q;
  assign save_y_end = save_y_end_q;
  assign bbox_valid = bbox_valid_q;
  assign bbox_found = bbox_found_q;

endmodule
`default_nettype wire

// File: tb/tb_proj_bbox_locator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proj_bbox_locator
//  Description : Self-checking bench for proj_bbox_locator on a 16x8 frame.
//                Directed frames plus random frames against a frame-level
//                reference model. Honours PROJ_LONGEST_RUN_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proj_bbox_locator;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 4;
  localparam int CW = 5;
  localparam int MW = 6;

  logic          clk = 1'b0;
  logic          rst, vsync, de, xyp;
  logic [7:0]    gray;
  logic [AW-1:0] xpos, ypos;
  logic [CW-1:0] col_thr, row_thr;
  logic [MW-1:0] mxs, mxe, mys, mye;
  logic [AW-1:0] sxs, sys, sxe, sye;
  logic          bbox_valid, bbox_found, busy;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int vbase  = 0;

  logic [7:0] img [V][H];
  bit         roi [V][H];

  always #5 clk = ~clk;

  proj_bbox_locator #(
    .H_PIXEL(H), .V_PIXEL(V), .AW(AW), .CNT_W(CW), .BIN_LEVEL(255), .MW(MW)
  ) dut (
    .clk(clk), .rst(rst), .pre_frame_vsync(vsync), .pre_frame_de(de),
    .gray_b(gray), .xpos(xpos), .ypos(ypos), .x_y_p(xyp),
    .col_thr(col_thr), .row_thr(row_thr),
    .mrg_x_st(mxs), .mrg_x_end(mxe), .mrg_y_st(mys), .mrg_y_end(mye),
    .save_x_st(sxs), .save_y_st(sys), .save_x_end(sxe), .save_y_end(sye),
    .bbox_valid(bbox_valid), .bbox_found(bbox_found), .busy(busy)
  );

  // Count valid pulses, sampled well clear of the active edge
  always @(posedge clk) begin
    #2;
    if (bbox_valid) vcnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        img[y][x] = 8'd0;
        roi[y][x] = 1'b1;
      end
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y][x] = 8'd255;
  endtask

  // Drive one raster frame; abort_at >= 0 asserts rst at that pixel instead
  task automatic send_frame(input int abort_at);
    int i;
    while (busy && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("idle_before_frame", busy, 0);
    vbase = vcnt;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        if (y * H + x == abort_at) begin
          rst = 1'b1;
          de  = 1'b0;
          return;
        end
        de   = 1'b1;
        xpos = AW'(x);
        ypos = AW'(y);
        gray = img[y][x];
        xyp  = roi[y][x];
        @(negedge clk);
      end
    de   = 1'b0;
    gray = 8'd0;
    xyp  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic ef, input int exs, input int eys,
                             input int exe, input int eye);
    int i;
    while (!bbox_valid && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_valid"}, bbox_valid, 1);
    chk({tag, "_found"}, bbox_found, ef);
    chk({tag, "_xst"},   sxs, exs);
    chk({tag, "_yst"},   sys, eys);
    chk({tag, "_xend"},  sxe, exe);
    chk({tag, "_yend"},  sye, eye);
    @(negedge clk);
    chk({tag, "_pulse_end"}, bbox_valid, 0);
    chk({tag, "_pulses"}, vcnt - vbase, 1);
  endtask

  // Bounds of qualifying positions along one axis of length n
  function automatic void span(input bit q[H], input int n, output bit any,
                               output int first, output int last);
`ifdef PROJ_LONGEST_RUN_EN
    int run, best;
    run = 0;
    best = 0;
`endif
    any = 0;
    first = 0;
    last = 0;
`ifdef PROJ_LONGEST_RUN_EN
    for (int i = 0; i < n; i++) begin
      if (q[i]) begin
        run++;
        if (run > best) begin
          best  = run;
          first = i - run + 1;
          last  = i;
          any   = 1;
        end
      end else begin
        run = 0;
      end
    end
`else
    for (int i = 0; i < n; i++)
      if (q[i]) begin
        if (!any) first = i;
        last = i;
        any  = 1;
      end
`endif
  endfunction

  // Frame-level reference: projections, thresholds, bounds, margins
  task automatic model(output logic f, output int xs, output int ys, output int xe, output int ye);
    int colc[H];
    int rowc[V];
    bit cq[H];
    bit rq[H];
    bit ax, ay;
    int fx, lx, fy, ly;
    for (int x = 0; x < H; x++) colc[x] = 0;
    for (int y = 0; y < V; y++) rowc[y] = 0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (roi[y][x] && img[y][x] >= 8'd255) begin
          colc[x]++;
          rowc[y]++;
        end
    for (int x = 0; x < H; x++) begin
      if (colc[x] > 31) colc[x] = 31;
      cq[x] = (colc[x] >= int'(col_thr));
      rq[x] = 0;
    end
    for (int y = 0; y < V; y++) begin
      if (rowc[y] > 31) rowc[y] = 31;
      rq[y] = (rowc[y] >= int'(row_thr));
    end
    span(cq, H, ax, fx, lx);
    span(rq, V, ay, fy, ly);
    xs = fx + int'(mxs);
    if (xs > H - 1) xs = H - 1;
    ys = fy + int'(mys);
    if (ys > V - 1) ys = V - 1;
    xe = lx - int'(mxe);
    if (xe < 0) xe = 0;
    ye = ly - int'(mye);
    if (ye < 0) ye = 0;
    f = ax && ay && (xs <= xe) && (ys <= ye);
    if (!f) begin
      xs = 0;
      ys = 0;
      xe = H - 1;
      ye = V - 1;
    end
  endtask

  initial begin
    logic ef;
    int   exs, eys, exe, eye, v0;

    rst = 1'b1; vsync = 1'b0; de = 1'b0; xyp = 1'b0; gray = 8'd0;
    xpos = '0; ypos = '0;
    col_thr = CW'(1); row_thr = CW'(1);
    mxs = '0; mxe = '0; mys = '0; mye = '0;
    clear_img();
    repeat (3) @(negedge clk);
    chk("rst_xst", sxs, 0);
    chk("rst_yst", sys, 0);
    chk("rst_xend", sxe, H - 1);
    chk("rst_yend", sye, V - 1);
    chk("rst_valid", bbox_valid, 0);
    chk("rst_found", bbox_found, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;

    // Empty frame
    send_frame(-1);
    check_frame("empty", 0, 0, 0, H - 1, V - 1);

    // Plain rectangle
    rect(4, 9, 2, 5);
    send_frame(-1);
    check_frame("rect", 1, 4, 2, 9, 5);

    // Inward margins, then a start margin that empties the x axis
    mxs = 6'd1; mxe = 6'd2; mys = 6'd1; mye = 6'd1;
    send_frame(-1);
    check_frame("margin", 1, 5, 3, 7, 4);
    mxs = 6'd10;
    send_frame(-1);
    check_frame("margin_over", 0, 0, 0, H - 1, V - 1);
    mxs = '0; mxe = '0; mys = '0; mye = '0;

    // Noise pixel with threshold 2, ROI closed first then open
    img[0][13] = 8'd255;
    col_thr = CW'(2); row_thr = CW'(2);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) roi[y][x] = 1'b0;
    send_frame(-1);
    check_frame("roi_off", 0, 0, 0, H - 1, V - 1);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) roi[y][x] = 1'b1;
    send_frame(-1);
    check_frame("thr2", 1, 4, 2, 9, 5);

    // Reset in the middle of accumulation
    send_frame(40);
    @(negedge clk);
    chk("midrst_xst", sxs, 0);
    chk("midrst_yst", sys, 0);
    chk("midrst_xend", sxe, H - 1);
    chk("midrst_yend", sye, V - 1);
    chk("midrst_found", bbox_found, 0);
    rst = 1'b0;
    v0 = vcnt;
    repeat (80) @(negedge clk);
    chk("midrst_no_pulse", vcnt - v0, 0);
    send_frame(-1);
    check_frame("after_rst", 1, 4, 2, 9, 5);

    // Two column groups: longest run versus overall span
    clear_img();
    col_thr = CW'(1); row_thr = CW'(1);
    rect(1, 2, 2, 5);
    rect(6, 11, 2, 5);
    send_frame(-1);
`ifdef PROJ_LONGEST_RUN_EN
    check_frame("runs", 1, 6, 2, 11, 5);
`else
    check_frame("runs", 1, 1, 2, 11, 5);
`endif

    // Random frames against the reference model
    for (int k = 0; k < 10; k++) begin
      int x0, x1, y0, y1;
      clear_img();
      x0 = $urandom_range(0, H - 1); x1 = $urandom_range(x0, H - 1);
      y0 = $urandom_range(0, V - 1); y1 = $urandom_range(y0, V - 1);
      if (k != 0) rect(x0, x1, y0, y1);
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++) begin
          if ($urandom_range(0, 9) == 0) img[y][x] = 8'd255;
          if ($urandom_range(0, 11) == 0) img[y][x] = 8'd254;
          if ($urandom_range(0, 7) == 0) roi[y][x] = 1'b0;
        end
      col_thr = CW'($urandom_range(1, 3));
      row_thr = CW'($urandom_range(1, 4));
      mxs = MW'($urandom_range(0, 3)); mxe = MW'($urandom_range(0, 3));
      mys = MW'($urandom_range(0, 2)); mye = MW'($urandom_range(0, 2));
      model(ef, exs, eys, exe, eye);
      send_frame(-1);
      check_frame($sformatf("rnd%0d", k), ef, exs, eys, exe, eye);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
